// File: rtl/prefetch_if.sv
// -----------------------------------------------------------------------------
// prefetch_if
// Bundles the instruction-memory and decode-side signals of the prefetch unit.
//   master : the prefetch unit. It drives the fetch request and the queue head.
//   slave  : the environment (memory plus decode). It drives the memory
//            response, redirect and stall.
// Signals:
//   ihit, imemload          memory response for imemaddr
//   imemREN, imemaddr       fetch request and fetch address
//   redirect, redirect_pc   flush the queue and restart fetch at redirect_pc
//   stall                   decode cannot take the head entry
//   out_valid, out_instr, out_pc, out_npc   queue head
//   halt                    a halt instruction was dequeued (sticky)
//   count                   number of occupied queue entries
// -----------------------------------------------------------------------------
interface prefetch_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ihit;
    logic [31:0]   imemload;
    logic          imemREN;
    logic [31:0]   imemaddr;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          stall;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_npc;
    logic          halt;
    logic [CW-1:0] count;

    modport master (
        input  ihit, imemload, redirect, redirect_pc, stall,
        output imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc,
               halt, count
    );

    modport slave (
        output ihit, imemload, redirect, redirect_pc, stall,
        input  imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc,
               halt, count
    );
endinterface

// File: rtl/prefetch_unit.sv
// -----------------------------------------------------------------------------
// prefetch_unit
// Instruction prefetcher. It fetches sequential words into a small circular
// queue and presents the oldest entry to decode. A redirect flushes the queue
// and restarts fetch. A fetched halt word (opcode 6'b111111) stops further
// requests. When that word is dequeued, the unit raises halt and parks in
// DONE until reset.
//
// Ports:
//   CLK   single clock; all state changes on its rising edge
//   nRST  asynchronous active-low reset
//   bus   prefetch_if.master (memory request/response, redirect, stall,
//         queue head, halt, count)
//
// Parameters:
//   PC_INIT  fetch address after reset
//   DEPTH    number of queue entries (power of two, >= 2)
//
// Optional feature:
//   PREFETCH_JPREDECODE_EN  When this macro is defined, a pushed J-format word
//                           (opcode 6'b000010) steers fetch_pc straight to the
//                           jump target. The J word is still enqueued.
// -----------------------------------------------------------------------------
module prefetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          DEPTH   = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [5:0]    OP_HALT    = 6'b111111;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           halt_q, halt_d;

    logic [31:0]    pc_mem_q    [DEPTH];
    logic [31:0]    instr_mem_q [DEPTH];

    logic           imem_ren;
    logic           head_valid;
    logic           push;
    logic           pop;
    logic [31:0]    fetch_pc_plus4;
    logic [31:0]    push_next_pc;
    logic [31:0]    head_instr;
    logic [31:0]    head_pc;

    // The request is masked while reset is held. This keeps imemREN low
    // during reset even though the reset state itself is FETCH with an
    // empty queue.
    assign imem_ren   = nRST && (state_q == FETCH) && (count_q < FULL_COUNT);
    assign head_valid = (state_q != DONE) && (count_q != '0);
    assign push       = bus.ihit && imem_ren && !bus.redirect;
    assign pop        = head_valid && !bus.stall && !bus.redirect;

    assign head_instr = instr_mem_q[head_q];
    assign head_pc    = pc_mem_q[head_q];

    assign fetch_pc_plus4 = fetch_pc_q + 32'd4;

    // Address that fetch moves to after a successful push.
    always_comb begin
        push_next_pc = fetch_pc_plus4;
`ifdef PREFETCH_JPREDECODE_EN
        if (bus.imemload[31:26] == 6'b000010) begin
            push_next_pc = {fetch_pc_plus4[31:28], bus.imemload[25:0], 2'b00};
        end
`endif
    end

    // Next-state logic. A redirect outside DONE overrides push, pop and halt
    // detection in the same cycle. The pop update comes after the push
    // update, so a dequeued halt (DONE) wins over a newly fetched one
    // (HALTED).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        halt_d     = halt_q;

        if (bus.redirect && (state_q != DONE)) begin
            state_d    = FETCH;
            fetch_pc_d = bus.redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                tail_d     = tail_q + PW'(1);
                fetch_pc_d = push_next_pc;
                if (bus.imemload[31:26] == OP_HALT) begin
                    state_d = HALTED;
                end
            end
            if (pop) begin
                head_d = head_q + PW'(1);
                if (head_instr[31:26] == OP_HALT) begin
                    halt_d  = 1'b1;
                    state_d = DONE;
                end
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            fetch_pc_q <= PC_INIT;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            halt_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            halt_q     <= halt_d;
            if (push) begin
                pc_mem_q[tail_q]    <= fetch_pc_q;
                instr_mem_q[tail_q] <= bus.imemload;
            end
        end
    end

    assign bus.imemREN   = imem_ren;
    assign bus.imemaddr  = fetch_pc_q;
    assign bus.out_valid = head_valid;
    assign bus.out_instr = head_instr;
    assign bus.out_pc    = head_pc;
    assign bus.out_npc   = head_pc + 32'd4;
    assign bus.halt      = halt_q;
    assign bus.count     = count_q;
endmodule
